// File: rtl/sudoku_pkg.sv
// Purpose: shared types and elaboration helpers for the sudoku grid decoder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sudoku_pkg;

  // Grid assembly phases: collecting rows, then presenting the finished grid.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Width needed to count every cell of an n x n grid as empty (0..n*n).
  function automatic int calc_cw(input int n);
    return $clog2(n * n + 1);
  endfunction

  // A code field must be able to express every digit 1..n plus the empty code 0.
  function automatic bit param_ok(input int n, input int dw);
    return (n >= 2) && ((1 << dw) > n);
  endfunction

endpackage

// File: rtl/sudoku_digit_onehot.sv
// Purpose: decode one packed digit code into an N-bit one-hot with bad/empty flags.
// Latency: combinational.
// Backpressure: none, pure function of the code.
module sudoku_digit_onehot #(
  parameter int N  = 9,
  parameter int DW = 4
) (
  input  logic [DW-1:0] code,
  output logic [N-1:0]  onehot,
  output logic          bad,
  output logic          empty
);

  // Code k in 1..N lights bit k-1; 0 is an empty cell; anything above N is illegal.
  always_comb begin
    onehot = '0;
    for (int k = 1; k <= N; k++) begin
      onehot[k-1] = (int'(code) == k);
    end
    empty = (code == '0);
    bad   = (int'(code) > N);
  end

endmodule

// File: rtl/sudoku_grid_decoder.sv
// Purpose: assemble an N x N one-hot grid from row beats; flag bad codes, empties, row duplicates.
// Latency: row visible in out_grid one edge after accept; out_valid one edge after the last row.
// Backpressure: in_ready low while a finished grid waits for out_ready; clear aborts assembly.
module sudoku_grid_decoder
  import sudoku_pkg::*;
#(
  parameter int N  = 9,
  parameter int DW = 4,
  parameter int CW = calc_cw(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      in_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*N*N-1:0]     out_grid,
  output logic                 out_bad_code,
  output logic [CW-1:0]        out_empty_cnt,
  output logic [N-1:0]         out_dup_row
);

  localparam int RW = $clog2(N);

  if (!param_ok(N, DW)) begin : g_param_chk
    $error("sudoku_grid_decoder: need N >= 2 and 2**DW > N");
  end

  state_e             state_q, state_d;
  logic [RW-1:0]      row_idx_q, row_idx_d;
  logic [N*N*N-1:0]   grid_q, grid_d;
  logic               bad_q, bad_d;
  logic [CW-1:0]      empty_q, empty_d;
  logic [N-1:0]       dup_q, dup_d;
  logic               rdy_en_q, rdy_en_d;

  logic [N*N-1:0]     row_oh;
  logic [N-1:0]       cell_bad;
  logic [N-1:0]       cell_empty;
  logic               row_bad;
  logic               row_dup;
  logic [CW-1:0]      row_empty_cnt;
  logic               accept;

  for (genvar c = 0; c < N; c++) begin : g_cell
    sudoku_digit_onehot #(
      .N  (N),
      .DW (DW)
    ) u_cell (
      .code   (in_row[c*DW +: DW]),
      .onehot (row_oh[c*N +: N]),
      .bad    (cell_bad[c]),
      .empty  (cell_empty[c])
    );
  end

  // Per-row statistics: a digit is duplicated when its bit appears in a cell after already being seen.
  always_comb begin
    logic [N-1:0] seen;
    logic [N-1:0] dup_bits;
    seen          = '0;
    dup_bits      = '0;
    row_empty_cnt = '0;
    for (int c = 0; c < N; c++) begin
      dup_bits      = dup_bits | (seen & row_oh[c*N +: N]);
      seen          = seen | row_oh[c*N +: N];
      row_empty_cnt = row_empty_cnt + CW'(cell_empty[c]);
    end
    row_dup = |dup_bits;
    row_bad = |cell_bad;
  end

  assign in_ready      = rdy_en_q && (state_q == FILL);
  assign out_valid     = (state_q == HOLD);
  assign out_grid      = grid_q;
  assign out_bad_code  = bad_q;
  assign out_empty_cnt = empty_q;
  assign out_dup_row   = dup_q;
  assign accept        = in_valid && in_ready;

  // Next-state: clear wins; FILL writes rows and accumulates flags; HOLD waits for the consumer.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    grid_d    = grid_q;
    bad_d     = bad_q;
    empty_d   = empty_q;
    dup_d     = dup_q;
    rdy_en_d  = 1'b1;
    if (clear) begin
      state_d   = FILL;
      row_idx_d = '0;
      bad_d     = 1'b0;
      empty_d   = '0;
      dup_d     = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            grid_d[int'(row_idx_q)*N*N +: N*N] = row_oh;
            bad_d                              = bad_q | row_bad;
            empty_d                            = empty_q + row_empty_cnt;
            dup_d[row_idx_q]                   = row_dup;
            if (row_idx_q == RW'(N - 1)) begin
              row_idx_d = '0;
              state_d   = HOLD;
            end else begin
              row_idx_d = row_idx_q + RW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = FILL;
            bad_d   = 1'b0;
            empty_d = '0;
            dup_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State register; reset wipes everything including a half-built grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      row_idx_q <= '0;
      grid_q    <= '0;
      bad_q     <= 1'b0;
      empty_q   <= '0;
      dup_q     <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      grid_q    <= grid_d;
      bad_q     <= bad_d;
      empty_q   <= empty_d;
      dup_q     <= dup_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

endmodule
